// File: rtl/imem_fetch.sv
// Instruction fetch unit: walks a bounded PC window, issues one-outstanding reads to
// instruction memory and buffers returned words in a 2-entry FIFO for the decoder.
module imem_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h8002_0000,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fault
);

  localparam logic [31:0] LAST_PC = RESET_PC + 32'(MEM_DEPTH) - 32'd4;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, FAULT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [1:0]  count_reg, count_next;
  logic [31:0] head_pc_reg, head_pc_next;
  logic [31:0] head_word_reg, head_word_next;
  logic [31:0] tail_pc_reg, tail_pc_next;
  logic [31:0] tail_word_reg, tail_word_next;
  logic        inst_valid_reg, inst_valid_next;
  logic        mem_req_reg, mem_req_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic        fault_reg, fault_next;

  logic        push;
  logic        pop;
  logic [31:0] pc_inc;
  logic [1:0]  occ_after_push;

  function automatic logic is_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr >= RESET_PC) && (addr <= LAST_PC);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= RESET_PC;
      count_reg      <= 2'd0;
      head_pc_reg    <= 32'd0;
      head_word_reg  <= 32'd0;
      tail_pc_reg    <= 32'd0;
      tail_word_reg  <= 32'd0;
      inst_valid_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= 32'd0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      count_reg      <= count_next;
      head_pc_reg    <= head_pc_next;
      head_word_reg  <= head_word_next;
      tail_pc_reg    <= tail_pc_next;
      tail_word_reg  <= tail_word_next;
      inst_valid_reg <= inst_valid_next;
      mem_req_reg    <= mem_req_next;
      mem_addr_reg   <= mem_addr_next;
      fault_reg      <= fault_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    count_next     = count_reg;
    head_pc_next   = head_pc_reg;
    head_word_next = head_word_reg;
    tail_pc_next   = tail_pc_reg;
    tail_word_next = tail_word_reg;
    mem_req_next   = mem_req_reg;
    mem_addr_next  = mem_addr_reg;
    fault_next     = fault_reg;
    push           = 1'b0;
    pop            = inst_valid_reg & inst_ready;
    pc_inc         = fetch_pc_reg + 32'd4;
    occ_after_push = count_reg + 2'd1 - {1'b0, pop};

    case (state_reg)
      IDLE: begin
        // A redirect empties the FIFO, so a legal target can be requested at once.
        if (redirect) begin
          fetch_pc_next = redirect_pc;
          if (is_legal(redirect_pc)) begin
            state_next    = REQ;
            mem_req_next  = 1'b1;
            mem_addr_next = redirect_pc;
          end else begin
            state_next = FAULT;
            fault_next = 1'b1;
          end
        end else if (!is_legal(fetch_pc_reg)) begin
          state_next = FAULT;
          fault_next = 1'b1;
        end else if (count_reg < 2'd2) begin
          state_next    = REQ;
          mem_req_next  = 1'b1;
          mem_addr_next = fetch_pc_reg;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (redirect) begin
            fetch_pc_next = redirect_pc;
            mem_req_next  = 1'b0;
            if (is_legal(redirect_pc)) begin
              state_next = IDLE;
            end else begin
              state_next = FAULT;
              fault_next = 1'b1;
            end
          end else begin
            push          = 1'b1;
            fetch_pc_next = pc_inc;
            if (!is_legal(pc_inc)) begin
              state_next   = FAULT;
              fault_next   = 1'b1;
              mem_req_next = 1'b0;
            end else if (occ_after_push < 2'd2) begin
              mem_addr_next = pc_inc;
            end else begin
              state_next   = IDLE;
              mem_req_next = 1'b0;
            end
          end
        end else if (redirect) begin
          fetch_pc_next = redirect_pc;
          state_next    = DRAIN;
        end
      end
      DRAIN: begin
        // The old request must complete on the bus; its data is dropped.
        if (redirect) begin
          fetch_pc_next = redirect_pc;
        end
        if (mem_ack) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
        end
      end
      FAULT: begin
        if (redirect) begin
          fetch_pc_next = redirect_pc;
          if (is_legal(redirect_pc)) begin
            state_next = IDLE;
            fault_next = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (redirect) begin
      count_next = 2'd0;
    end else begin
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
      if (pop && (count_reg == 2'd2)) begin
        head_pc_next   = tail_pc_reg;
        head_word_next = tail_word_reg;
      end
      if (push) begin
        if ((count_reg == 2'd0) || ((count_reg == 2'd1) && pop)) begin
          head_pc_next   = fetch_pc_reg;
          head_word_next = mem_rdata;
        end else begin
          tail_pc_next   = fetch_pc_reg;
          tail_word_next = mem_rdata;
        end
      end
    end

    inst_valid_next = (count_next != 2'd0);
  end

  assign mem_req    = mem_req_reg;
  assign mem_addr   = mem_addr_reg;
  assign inst_valid = inst_valid_reg;
  assign inst       = head_word_reg;
  assign inst_pc    = head_pc_reg;
  assign fault      = fault_reg;

endmodule
